// File: rtl/beat_map_sequencer.sv
// beat_map_sequencer: steps through a song chart held in an external
// synchronous ROM, one row every TICK_DIV clocks, and emits one-cycle per-lane
// map strobes for the downstream note generators.
// Optional build macro LOOP_CHART_EN: the chart wraps to row 0 after the last
// row and done becomes a single-cycle pulse on the wrap step.
module beat_map_sequencer #(
  parameter int TICK_DIV  = 4,
  parameter int CHART_LEN = 64,
  parameter int ADDR_W    = 6,
  parameter int LANES     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  input  logic [LANES-1:0]  chart_data,
  output logic [ADDR_W-1:0] chart_addr,
  output logic [LANES-1:0]  map,
  output logic              step_tick,
  output logic              playing,
  output logic              done
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CHART_LEN - 1);

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [LANES-1:0]  map_q,     map_d;
  logic              step_q,    step_d;
  logic              playing_q, playing_d;
  logic              done_q,    done_d;
`ifdef LOOP_CHART_EN
  logic              wrap;
`endif

  // Next-state: tick counting, row stepping and start/pause/end handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    map_d   = '0;
    step_d  = 1'b0;
`ifdef LOOP_CHART_EN
    wrap    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        addr_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (pause) begin
          // The cycle that sees pause still counts, but a step is never
          // taken; at the last tick the counter waits so the step is deferred.
          state_d = S_PAUSE;
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          map_d  = chart_data;
          step_d = 1'b1;
          if (addr_q == ADDR_LAST) begin
`ifdef LOOP_CHART_EN
            addr_d = '0;
            wrap   = 1'b1;
`else
            state_d = S_DONE;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (!pause) state_d = S_RUN;
      end
      S_DONE: begin
        if (start) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the current state, so they trail the
    // state transition by one cycle.
    playing_d = (state_q == S_RUN) || (state_q == S_PAUSE);
`ifdef LOOP_CHART_EN
    done_d = wrap;
`else
    done_d = (state_q == S_DONE);
`endif
  end

  // State and output registers; reset cancels any strobe in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      map_q     <= '0;
      step_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      map_q     <= map_d;
      step_q    <= step_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign chart_addr = addr_q;
  assign map        = map_q;
  assign step_tick  = step_q;
  assign playing    = playing_q;
  assign done       = done_q;

endmodule

// File: doc/beat_map_sequencer.md
Name: beat_map_sequencer

Overview:
- Upstream stage of the per-lane note generators (data_generation_N).
- Walks a song chart stored in an external synchronous ROM at a fixed step rate, one chart row per step.
- For each step, emits one-cycle `map` strobes, one bit per lane; each bit drives the `map` input of that lane's note generator.
- Handles start, pause/resume and end-of-song.

Parameters:
- TICK_DIV, 4, clk cycles per chart step; must be >= 2.
- CHART_LEN, 64, number of chart rows in a song; must be >= 2.
- ADDR_W, 6, chart address width; 2**ADDR_W >= CHART_LEN.
- LANES, 8, number of note lanes; one map bit per lane.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  level; begins a song from row 0 when in IDLE or DONE.
- pause  input  1  level; freezes playback while high.
- chart_data  input  LANES  ROM read data; valid 1 cycle after chart_addr.
- chart_addr  output  ADDR_W  registered ROM address.
- map  output  LANES  one-cycle strobe per lane on each step.
- step_tick  output  1  one-cycle pulse on every step taken.
- playing  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Clock and reset: single clock `clk`. `resetn` is asynchronous and active-low.
- Reset values: state=IDLE, chart_addr=0, tick counter=0, map=0, step_tick=0, playing=0, done=0.
- States:
  - IDLE: counter=0, chart_addr=0. start=1 -> RUN.
  - RUN: counter increments each cycle.
    - When counter==TICK_DIV-1, a step occurs:
      - map<=chart_data, step_tick<=1, counter<=0.
      - If chart_addr==CHART_LEN-1: go to DONE. Otherwise chart_addr<=chart_addr+1.
    - pause=1 (sampled in RUN) -> PAUSE, with no step taken in that cycle.
  - PAUSE: counter and chart_addr are frozen; map=0, step_tick=0. pause=0 -> RUN, and counting resumes from the frozen value.
  - DONE: done=1, playing=0, map=0. start=1 -> chart_addr<=0, counter<=0, state RUN.
- Strobe timing:
  - map and step_tick are registered and high for exactly one cycle per step; they are 0 in every other cycle.
  - The first step occurs TICK_DIV cycles after the cycle in which start is sampled.
  - Steps are then spaced TICK_DIV cycles apart.
- ROM timing: chart_addr changes only at a step. With TICK_DIV >= 2, chart_data is stable before the next step samples it.
- Control precedence:
  - start is ignored in RUN and PAUSE.
  - start and pause both high in IDLE: enter RUN; pause moves to PAUSE on the following cycle, before any step.
  - pause in IDLE or DONE: ignored.
- Reset mid-song: asynchronous return to reset values; any strobe in flight is cancelled.
- Widths: counter width is clog2(TICK_DIV). chart_addr never exceeds CHART_LEN-1.
- playing: registered, equals (state==RUN || state==PAUSE).

Optional Feature:
- Macro: LOOP_CHART_EN
- Defined:
  - At the step on row CHART_LEN-1, chart_addr wraps to 0 and the state stays RUN.
  - done pulses high for one cycle, coincident with that step_tick.
  - DONE is unreachable.
- Not defined: the song ends in DONE as described above. done is a held level until start.

Test Plan:
- TICK_DIV=4, CHART_LEN=4, ROM rows {0x01,0x02,0x80,0xFF}; start pulsed at cycle 0 -> map=0x01,0x02,0x80,0xFF at cycles 4,8,12,16, each 1 cycle wide; done=1 from cycle 17; playing=0 afterwards.
- Same setup; pause high for cycles 6-15 -> no map or step_tick during the pause; the row-1 strobe (0x02) arrives 2 cycles after pause drops, then 4-cycle spacing resumes; total of 4 strobes.
- resetn low at cycle 9 (mid-song) -> all outputs 0 immediately; chart_addr=0; after release, no strobe until start.
- In DONE, assert start -> strobes replay from row 0; in RUN, start=1 has no effect on chart_addr or spacing.
- start and pause both high in IDLE -> playing=1, state PAUSE after 1 cycle, no strobes until pause falls.
- LOOP_CHART_EN defined, same ROM -> after 0xFF at cycle 16, 0x01 at cycle 20; done single-cycle pulses at cycles 16 and 32; playing remains 1.
